sram_port_arbiter: RTL and testbench

- Shares the single-port 256x4 SRAM between the March C BIST engine and two functional requesters.
- Sits between those masters and the SRAM; it is the only block that drives SRAM addr/data/w_en.
- BIST takes absolute priority once in-flight functional reads drain; functional requesters are served round-robin, one access per cycle.

---
 rtl/sram_port_arbiter.sv | 129 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port SRAM between the BIST engine and two round-robin functional requesters.
// Functional reads return through an RD_LAT-deep one-hot tag pipeline; BIST waits for it to drain.
module sram_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bist_req,
    output logic              bist_gnt,
    input  logic [ADDR_W-1:0] bist_addr,
    input  logic [DATA_W-1:0] bist_wdat,
    input  logic              bist_wen,
    output logic [DATA_W-1:0] bist_rdat,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdat0,
    input  logic [DATA_W-1:0] wdat1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dat,
    output logic              sram_wen,
    input  logic [DATA_W-1:0] sram_rdat,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, FUNC, DRAIN, BIST} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_ptr;
    logic [1:0]        r_tag [RD_LAT];
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dat;

    logic              w_arb_en;
    logic              w_sel;
    logic [1:0]        w_gnt;
    logic [1:0]        w_push;
    logic              w_drained;

    assign w_arb_en = ((r_state == IDLE) || (r_state == FUNC)) && !bist_req;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_gnt = 2'b00;
        w_sel = 1'b0;
        if (w_arb_en && (req != 2'b00)) begin
            w_sel = (req == 2'b11) ? r_ptr : req[1];
            w_gnt = w_sel ? 2'b10 : 2'b01;
        end
    end

    assign gnt      = w_gnt;
    assign bist_gnt = (r_state == BIST) && bist_req;
    assign w_push   = w_gnt & ~we;

    always_comb begin
        sram_addr = r_addr;
        sram_dat  = r_dat;
        sram_wen  = 1'b0;
        if (bist_gnt) begin
            sram_addr = bist_addr;
            sram_dat  = bist_wdat;
            sram_wen  = bist_wen;
        end else if (w_gnt != 2'b00) begin
            sram_addr = w_sel ? addr1 : addr0;
            sram_dat  = w_sel ? wdat1 : wdat0;
            sram_wen  = we[w_sel];
        end
    end

    // The last pipeline stage is being returned this cycle, so only earlier stages can still block BIST.
    always_comb begin
        w_drained = 1'b1;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            if (r_tag[i] != 2'b00) w_drained = 1'b0;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bist_req) w_next = DRAIN;
                     else if (req != 2'b00) w_next = FUNC;
            FUNC:    if (bist_req) w_next = DRAIN;
                     else if (req == 2'b00) w_next = IDLE;
            DRAIN:   if (w_drained) w_next = bist_req ? BIST : IDLE;
            BIST:    if (!bist_req) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= 1'b0;
            r_addr  <= '0;
            r_dat   <= '0;
        end else begin
            r_state <= w_next;
            r_addr  <= sram_addr;
            r_dat   <= sram_dat;
            if (w_gnt != 2'b00) r_ptr <= ~w_sel;
        end
    end

    // NOTE: the tag pipeline is control state, so every stage is reset; a stale tag would fire a phantom rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) r_tag[i] <= 2'b00;
        end else begin
            r_tag[0] <= w_push;
            for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    assign rvalid    = r_tag[RD_LAT-1];
    assign rdata     = (rvalid != 2'b00) ? sram_rdat : '0;
    assign bist_rdat = sram_rdat;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: two arbiters (RD_LAT=1 and RD_LAT=2) share stimulus, each driving its own SRAM model.
module tb_sram_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic       bist_req;
    logic [7:0] bist_addr;
    logic [3:0] bist_wdat;
    logic       bist_wen;
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] addr0, addr1;
    logic [3:0] wdat0, wdat1;

    logic       bist_gnt_1, bist_gnt_2;
    logic [3:0] bist_rdat_1, bist_rdat_2;
    logic [1:0] gnt_1, gnt_2;
    logic [1:0] rvalid_1, rvalid_2;
    logic [3:0] rdata_1, rdata_2;
    logic [7:0] sram_addr_1, sram_addr_2;
    logic [3:0] sram_dat_1, sram_dat_2;
    logic       sram_wen_1, sram_wen_2;
    logic [3:0] sram_rdat_1, sram_rdat_2;
    logic       busy_1, busy_2;

    logic       pre_we;
    logic [7:0] pre_a;
    logic [3:0] pre_d;

    int n_checks = 0;
    int n_errors = 0;

    sram_port_arbiter #(.ADDR_W(8), .DATA_W(4), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .bist_req(bist_req), .bist_gnt(bist_gnt_1), .bist_addr(bist_addr),
        .bist_wdat(bist_wdat), .bist_wen(bist_wen), .bist_rdat(bist_rdat_1),
        .req(req), .we(we), .addr0(addr0), .addr1(addr1), .wdat0(wdat0), .wdat1(wdat1),
        .gnt(gnt_1), .rvalid(rvalid_1), .rdata(rdata_1),
        .sram_addr(sram_addr_1), .sram_dat(sram_dat_1), .sram_wen(sram_wen_1),
        .sram_rdat(sram_rdat_1), .busy(busy_1)
    );

    sram_port_arbiter #(.ADDR_W(8), .DATA_W(4), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .bist_req(bist_req), .bist_gnt(bist_gnt_2), .bist_addr(bist_addr),
        .bist_wdat(bist_wdat), .bist_wen(bist_wen), .bist_rdat(bist_rdat_2),
        .req(req), .we(we), .addr0(addr0), .addr1(addr1), .wdat0(wdat0), .wdat1(wdat1),
        .gnt(gnt_2), .rvalid(rvalid_2), .rdata(rdata_2),
        .sram_addr(sram_addr_2), .sram_dat(sram_dat_2), .sram_wen(sram_wen_2),
        .sram_rdat(sram_rdat_2), .busy(busy_2)
    );

    // SRAM models: synchronous write, read data after 1 or 2 clocks.
    logic [3:0] mem1 [256];
    logic [3:0] mem2 [256];
    logic [3:0] rp1, rp2a, rp2b;

    always @(posedge clk) begin
        if (pre_we) begin
            mem1[pre_a] <= pre_d;
            mem2[pre_a] <= pre_d;
        end else begin
            if (sram_wen_1) mem1[sram_addr_1] <= sram_dat_1;
            if (sram_wen_2) mem2[sram_addr_2] <= sram_dat_2;
        end
        rp1  <= mem1[sram_addr_1];
        rp2a <= mem2[sram_addr_2];
        rp2b <= rp2a;
    end

    assign sram_rdat_1 = rp1;
    assign sram_rdat_2 = rp2b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Packed control view: {bist_gnt, busy, gnt, rvalid, rdata}.
    task automatic exp_ctl(input string tag, input int d, input logic bg, input logic b,
                           input logic [1:0] g, input logic [1:0] rv, input logic [3:0] rd);
        logic [9:0] got;
        got = (d == 1) ? {bist_gnt_1, busy_1, gnt_1, rvalid_1, rdata_1}
                       : {bist_gnt_2, busy_2, gnt_2, rvalid_2, rdata_2};
        check($sformatf("%s_d%0d_ctl", tag, d), 32'(got), 32'({bg, b, g, rv, rd}));
    endtask

    // Packed SRAM-side view: {sram_addr, sram_dat, sram_wen}.
    task automatic exp_sram(input string tag, input int d, input logic [7:0] a,
                            input logic [3:0] dt, input logic w);
        logic [12:0] got;
        got = (d == 1) ? {sram_addr_1, sram_dat_1, sram_wen_1}
                       : {sram_addr_2, sram_dat_2, sram_wen_2};
        check($sformatf("%s_d%0d_sram", tag, d), 32'(got), 32'({a, dt, w}));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rd_of(input logic [1:0] rv);
        return (rv == 2'b01) ? 4'h5 : (rv == 2'b10) ? 4'hA : 4'h0;
    endfunction

    localparam logic [1:0] RR_G   [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    localparam logic [1:0] RR_RV1 [6] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    localparam logic [1:0] RR_RV2 [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    localparam logic       RR_B   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [7:0] RR_A   [6] = '{8'h10, 8'h20, 8'h10, 8'h20, 8'h20, 8'h20};

    initial begin
        rst_n = 1'b0; bist_req = 1'b0; bist_addr = '0; bist_wdat = '0; bist_wen = 1'b0;
        req = 2'b00; we = 2'b00; addr0 = '0; addr1 = '0; wdat0 = '0; wdat1 = '0;
        pre_we = 1'b0; pre_a = '0; pre_d = '0;

        // Preload while held in reset.
        step();
        pre_we = 1'b1; pre_a = 8'h10; pre_d = 4'h5; step();
        pre_a = 8'h20; pre_d = 4'hA; step();
        pre_we = 1'b0;
        @(negedge clk);
        for (int d = 1; d <= 2; d++) begin
            exp_ctl("reset", d, 1'b0, 1'b0, 2'b00, 2'b00, 4'h0);
            exp_sram("reset", d, 8'h00, 4'h0, 1'b0);
        end
        step();
        rst_n = 1'b1;
        step();

        // Round-robin: both requesters read for 4 cycles.
        addr0 = 8'h10; addr1 = 8'h20; we = 2'b00;
        for (int k = 0; k < 6; k++) begin
            req = (k < 4) ? 2'b11 : 2'b00;
            @(negedge clk);
            exp_ctl($sformatf("rr%0d", k), 1, 1'b0, RR_B[k], RR_G[k], RR_RV1[k], rd_of(RR_RV1[k]));
            exp_ctl($sformatf("rr%0d", k), 2, 1'b0, RR_B[k], RR_G[k], RR_RV2[k], rd_of(RR_RV2[k]));
            exp_sram($sformatf("rr%0d", k), 1, RR_A[k], 4'h0, 1'b0);
            step();
        end

        // Requester 1 writes 0x3 to 0xFF, then reads it back.
        req = 2'b10; we = 2'b10; addr1 = 8'hFF; wdat1 = 4'h3;
        @(negedge clk);
        for (int d = 1; d <= 2; d++) begin
            exp_ctl("wr", d, 1'b0, 1'b0, 2'b10, 2'b00, 4'h0);
            exp_sram("wr", d, 8'hFF, 4'h3, 1'b1);
        end
        step();
        we = 2'b00;
        @(negedge clk);
        exp_ctl("rdreq", 1, 1'b0, 1'b1, 2'b10, 2'b00, 4'h0);
        exp_sram("rdreq", 2, 8'hFF, 4'h3, 1'b0);
        step();
        req = 2'b00;
        @(negedge clk);
        exp_ctl("rdback1", 1, 1'b0, 1'b1, 2'b00, 2'b10, 4'h3);
        exp_ctl("rdback1", 2, 1'b0, 1'b1, 2'b00, 2'b00, 4'h0);
        exp_sram("hold", 1, 8'hFF, 4'h3, 1'b0);
        step();
        @(negedge clk);
        exp_ctl("rdback2", 1, 1'b0, 1'b0, 2'b00, 2'b00, 4'h0);
        exp_ctl("rdback2", 2, 1'b0, 1'b0, 2'b00, 2'b10, 4'h3);
        step();

        // Reset in the middle of a read; pointer was left on requester 1.
        req = 2'b01; addr0 = 8'h10;
        @(negedge clk);
        exp_ctl("prerst", 1, 1'b0, 1'b0, 2'b01, 2'b00, 4'h0);
        step();
        req = 2'b00; rst_n = 1'b0;
        @(negedge clk);
        for (int d = 1; d <= 2; d++) begin
            exp_ctl("midrst", d, 1'b0, 1'b0, 2'b00, 2'b00, 4'h0);
            exp_sram("midrst", d, 8'h00, 4'h0, 1'b0);
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            exp_ctl($sformatf("postrst%0d", k), 1, 1'b0, 1'b0, 2'b00, 2'b00, 4'h0);
            exp_ctl($sformatf("postrst%0d", k), 2, 1'b0, 1'b0, 2'b00, 2'b00, 4'h0);
            step();
        end
        req = 2'b11;
        @(negedge clk);
        exp_ctl("ptr0", 1, 1'b0, 1'b0, 2'b01, 2'b00, 4'h0);
        exp_ctl("ptr0", 2, 1'b0, 1'b0, 2'b01, 2'b00, 4'h0);
        step();
        req = 2'b00;
        @(negedge clk);
        exp_ctl("ptr0rv", 1, 1'b0, 1'b1, 2'b00, 2'b01, 4'h5);
        step();
        @(negedge clk);
        exp_ctl("ptr0rv", 2, 1'b0, 1'b0, 2'b00, 2'b01, 4'h5);
        step();

        // BIST preemption behind an in-flight requester-0 read.
        req = 2'b01; addr0 = 8'h20;
        @(negedge clk);
        exp_ctl("pre0", 2, 1'b0, 1'b0, 2'b01, 2'b00, 4'h0);
        step();
        bist_req = 1'b1;
        @(negedge clk);
        exp_ctl("pre1", 1, 1'b0, 1'b1, 2'b00, 2'b01, 4'hA);
        exp_ctl("pre1", 2, 1'b0, 1'b1, 2'b00, 2'b00, 4'h0);
        step();
        @(negedge clk);
        exp_ctl("drain", 1, 1'b0, 1'b1, 2'b00, 2'b00, 4'h0);
        exp_ctl("drain", 2, 1'b0, 1'b1, 2'b00, 2'b01, 4'hA);
        step();

        // March pass: write 0 everywhere, then read everything back.
        for (int a = 0; a < 256; a++) begin
            bist_wen = 1'b1; bist_addr = 8'(a); bist_wdat = 4'h0;
            @(negedge clk);
            for (int d = 1; d <= 2; d++) begin
                exp_ctl("bist_w", d, 1'b1, 1'b1, 2'b00, 2'b00, 4'h0);
                exp_sram("bist_w", d, 8'(a), 4'h0, 1'b1);
            end
            step();
        end
        for (int a = 0; a < 256; a++) begin
            bist_wen = 1'b0; bist_addr = 8'(a); bist_wdat = 4'h5;
            @(negedge clk);
            for (int d = 1; d <= 2; d++) begin
                exp_ctl("bist_r", d, 1'b1, 1'b1, 2'b00, 2'b00, 4'h0);
                exp_sram("bist_r", d, 8'(a), 4'h5, 1'b0);
            end
            if (a >= 2) begin
                check("bist_rdat_d1", 32'(bist_rdat_1), 32'h0);
                check("bist_rdat_d2", 32'(bist_rdat_2), 32'h0);
            end
            step();
        end

        // BIST release with requester 0 waiting.
        bist_req = 1'b0; bist_wen = 1'b1;
        @(negedge clk);
        for (int d = 1; d <= 2; d++) exp_ctl("rel0", d, 1'b0, 1'b1, 2'b00, 2'b00, 4'h0);
        check("rel0_wen_d1", 32'(sram_wen_1), 32'h0);
        check("rel0_wen_d2", 32'(sram_wen_2), 32'h0);
        step();
        bist_wen = 1'b0;
        @(negedge clk);
        for (int d = 1; d <= 2; d++) begin
            exp_ctl("rel1", d, 1'b0, 1'b0, 2'b01, 2'b00, 4'h0);
            exp_sram("rel1", d, 8'h20, 4'h0, 1'b0);
        end
        step();
        req = 2'b00;
        @(negedge clk);
        exp_ctl("rel2", 1, 1'b0, 1'b1, 2'b00, 2'b01, 4'h0);
        exp_ctl("rel2", 2, 1'b0, 1'b1, 2'b00, 2'b00, 4'h0);
        step();
        @(negedge clk);
        exp_ctl("rel3", 1, 1'b0, 1'b0, 2'b00, 2'b00, 4'h0);
        exp_ctl("rel3", 2, 1'b0, 1'b0, 2'b00, 2'b01, 4'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
